count_sched: RTL

Run scheduler for the shared 8-bit up-counter datapath. Arbitrates up to N_REQ requesters round-robin, grants one at a time, loads the counter with PRESET, advances it a requester-specified number of steps, then signals completion. It owns the counter register and exposes its value, so test-vector sweeps from several sources can share one counter without colliding.

---
 rtl/count_sched_if.sv | 35 +++
 rtl/count_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/count_sched_if.sv
// count_sched_if: requester-side bundle for the shared counter scheduler.
// Carries per-requester request/length, the grant/done one-hots, busy and the counter value.
interface count_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       count;

  // Requester side drives requests and lengths, observes the scheduler
  modport master (
    output req,
    output len,
    input  grant,
    input  busy,
    input  done,
    input  count
  );

  // Scheduler side
  modport slave (
    input  req,
    input  len,
    output grant,
    output busy,
    output done,
    output count
  );

endinterface

// File: rtl/count_sched.sv
// count_sched: round-robin run scheduler owning a shared up-counter.
// Each granted run loads PRESET, counts up len[winner] steps, then pulses done[winner].
// Optional feature macro: COUNT_SCHED_ABORT_EN -- when defined, dropping req[winner]
// during RUN abandons the run (back to IDLE, no done, count frozen).
module count_sched #(
  parameter int unsigned      N_REQ  = 4,
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] PRESET = 8'h04
) (
  input  logic         i_clk,
  input  logic         i_reset,
  count_sched_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PTR_W-1:0]   r_ptr;
  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic               r_busy;

  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0]   w_count_nxt;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [N_REQ-1:0]   w_grant_nxt;
  logic [N_REQ-1:0]   w_done_nxt;
  logic               w_busy_nxt;

  logic               w_win_valid;
  logic [PTR_W-1:0]   w_win_idx;
  logic [N_REQ-1:0]   w_win_onehot;
  logic [N_REQ-1:0]   w_own_onehot;
  logic [WIDTH-1:0]   w_len_sel;
`ifdef COUNT_SCHED_ABORT_EN
  logic               w_own_req;
`endif

  // Round-robin search: first set req bit starting just above the pointer, wrapping
  always_comb begin
    int unsigned      v_idx;
    logic [PTR_W-1:0] v_cand;
    w_win_valid = 1'b0;
    w_win_idx   = r_ptr;
    v_idx       = 0;
    v_cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      v_idx  = (32'(r_ptr) + k) % N_REQ;
      v_cand = PTR_W'(v_idx);
      if (!w_win_valid && bus.req[v_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = v_cand;
      end
    end
  end

  assign w_win_onehot = N_REQ'(1) << w_win_idx;
  assign w_own_onehot = N_REQ'(1) << r_ptr;

  // Run length of the current owner, picked out of the packed length bus
  always_comb begin
    w_len_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_ptr == PTR_W'(i)) begin
        w_len_sel = bus.len[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef COUNT_SCHED_ABORT_EN
  assign w_own_req = bus.req[r_ptr];
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_len_sel == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
`ifdef COUNT_SCHED_ABORT_EN
        if (!w_own_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_rem == WIDTH'(1)) begin
          w_state_nxt = S_DONE;
        end
`else
        if (r_rem == WIDTH'(1)) begin
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; every output is registered from these
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_rem_nxt   = r_rem;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_grant_nxt = w_win_onehot;
          w_ptr_nxt   = w_win_idx;
        end
      end
      S_LOAD: begin
        w_count_nxt = PRESET;
        w_rem_nxt   = w_len_sel;
        if (w_state_nxt == S_DONE) begin
          w_done_nxt = w_own_onehot;
        end
      end
      S_RUN: begin
        if (w_state_nxt == S_IDLE) begin
          // Abandoned run: release the counter, leave its value untouched
          w_grant_nxt = '0;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
          w_rem_nxt   = r_rem - WIDTH'(1);
          if (w_state_nxt == S_DONE) begin
            w_done_nxt = w_own_onehot;
          end
        end
      end
      S_DONE: begin
        w_grant_nxt = '0;
      end
      default: begin
        w_grant_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr   <= PTR_W'(N_REQ - 1);
      r_count <= '0;
      r_rem   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_rem   <= w_rem_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.count = r_count;

endmodule
